// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI mode-0 shift engine: FSM encoding,
// default clock divider and the counter widths the engine is built around.
package spi_shift_engine_pkg;

  typedef enum logic [1:0] {
    SPI_IDLE  = 2'd0,
    SPI_SETUP = 2'd1,
    SPI_XFER  = 2'd2,
    SPI_HOLD  = 2'd3
  } spi_state_e;

  localparam int SPI_CLK_DIV_DEFAULT = 4;
  localparam int SPI_DATA_W_DEFAULT  = 8;
  localparam int SPI_DIV_CNT_W       = 8;

  // Shift a word left by one place and insert a new LSB.
  function automatic logic [SPI_DATA_W_DEFAULT-1:0] shift_in(
    input logic [SPI_DATA_W_DEFAULT-1:0] word,
    input logic                          lsb
  );
    return {word[SPI_DATA_W_DEFAULT-2:0], lsb};
  endfunction

endpackage

// File: rtl/spi_shift_engine_clk_div.sv
// Half-period tick generator for the SPI engine. Counts clk cycles while
// the engine is busy and emits a one-cycle tick every CLK_DIV cycles; the
// count is cleared when a new transfer is accepted so every frame starts
// with a full half-period.
module spi_shift_engine_clk_div
  import spi_shift_engine_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam logic [SPI_DIV_CNT_W-1:0] DIV_LAST = SPI_DIV_CNT_W'(CLK_DIV - 1);

  logic [SPI_DIV_CNT_W-1:0] div_cnt_q;
  logic [SPI_DIV_CNT_W-1:0] div_cnt_d;

  // Next count and tick: wrap to zero at the terminal count, clear on start.
  always_comb begin
    div_cnt_d = div_cnt_q;
    tick      = 1'b0;
    if (clear) begin
      div_cnt_d = '0;
    end else if (en) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        tick      = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + SPI_DIV_CNT_W'(1);
      end
    end
  end

  // Divider count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// Byte-wide SPI master shift engine, mode 0 (CPOL=0, CPHA=0), MSB first.
// One accepted start produces one full-duplex transfer framed by ss.
// sck, ss and mosi are all taken straight from flops so the pins never glitch.
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT,
  parameter int DATA_W  = SPI_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              start,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              new_data,
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic              ss
);

  localparam int BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_W - 1);

  spi_state_e state_q, state_d;

  logic [DATA_W-1:0]    tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]    rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]    data_out_q, data_out_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 tail_q, tail_d;
  logic                 busy_q, busy_d;
  logic                 new_data_q, new_data_d;
  logic                 mosi_q, mosi_d;
  logic                 sck_q, sck_d;
  logic                 ss_q, ss_d;

  logic accept;
  logic tick;

  spi_shift_engine_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst   (rst),
    .en    (busy_q),
    .clear (accept),
    .tick  (tick)
  );

  // Next-state and pin logic. After the eighth falling edge sck stays low for
  // one more half-period (tail) so every sck cycle is a full 2*CLK_DIV long,
  // then HOLD keeps ss asserted for one further half-period before release.
  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    data_out_d = data_out_q;
    bit_cnt_d  = bit_cnt_q;
    tail_d     = tail_q;
    busy_d     = busy_q;
    new_data_d = 1'b0;
    mosi_d     = mosi_q;
    sck_d      = sck_q;
    ss_d       = ss_q;
    accept     = 1'b0;

    case (state_q)
      SPI_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          tx_sr_d   = data_in;
          mosi_d    = data_in[DATA_W-1];
          ss_d      = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          tail_d    = 1'b0;
          state_d   = SPI_SETUP;
        end
      end

      SPI_SETUP: begin
        if (tick) begin
          sck_d   = 1'b1;
          rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
          state_d = SPI_XFER;
        end
      end

      SPI_XFER: begin
        if (tick) begin
          if (tail_q) begin
            tail_d  = 1'b0;
            state_d = SPI_HOLD;
          end else if (sck_q) begin
            sck_d     = 1'b0;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_LAST) begin
              tail_d = 1'b1;
            end else begin
              tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
              mosi_d  = tx_sr_q[DATA_W-2];
            end
          end else begin
            sck_d   = 1'b1;
            rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
          end
        end
      end

      SPI_HOLD: begin
        if (tick) begin
          ss_d       = 1'b1;
          busy_d     = 1'b0;
          data_out_d = rx_sr_q;
          new_data_d = 1'b1;
          mosi_d     = 1'b0;
          state_d    = SPI_IDLE;
        end
      end

      default: begin
        state_d = SPI_IDLE;
      end
    endcase
  end

  // State, shift registers, counters and pin registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SPI_IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      data_out_q <= '0;
      bit_cnt_q  <= '0;
      tail_q     <= 1'b0;
      busy_q     <= 1'b0;
      new_data_q <= 1'b0;
      mosi_q     <= 1'b0;
      sck_q      <= 1'b0;
      ss_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      data_out_q <= data_out_d;
      bit_cnt_q  <= bit_cnt_d;
      tail_q     <= tail_d;
      busy_q     <= busy_d;
      new_data_q <= new_data_d;
      mosi_q     <= mosi_d;
      sck_q      <= sck_d;
      ss_q       <= ss_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign new_data = new_data_q;
  assign mosi     = mosi_q;
  assign sck      = sck_q;
  assign ss       = ss_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: one instance at CLK_DIV=4 and one at CLK_DIV=1.
// A frame-level model predicts every pin from the cycle offset since start.
module tb_spi_shift_engine;

  logic       clk;
  logic       rst;
  logic       start_v [2];
  logic [7:0] data_v  [2];
  logic       loop_v  [2];
  logic       tie_v   [2];
  logic       miso_w  [2];
  logic [7:0] dout_w  [2];
  logic       busy_w  [2];
  logic       nd_w    [2];
  logic       mosi_w  [2];
  logic       sck_w   [2];
  logic       ss_w    [2];

  int checks = 0;
  int errors = 0;

  spi_shift_engine #(.CLK_DIV(4), .DATA_W(8)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_v[0]), .start(start_v[0]),
    .data_out(dout_w[0]), .busy(busy_w[0]), .new_data(nd_w[0]),
    .miso(miso_w[0]), .mosi(mosi_w[0]), .sck(sck_w[0]), .ss(ss_w[0])
  );

  spi_shift_engine #(.CLK_DIV(1), .DATA_W(8)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_v[1]), .start(start_v[1]),
    .data_out(dout_w[1]), .busy(busy_w[1]), .new_data(nd_w[1]),
    .miso(miso_w[1]), .mosi(mosi_w[1]), .sck(sck_w[1]), .ss(ss_w[1])
  );

  assign miso_w[0] = loop_v[0] ? mosi_w[0] : tie_v[0];
  assign miso_w[1] = loop_v[1] ? mosi_w[1] : tie_v[1];

  // Free-running system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Frame model: whether a frame is in flight, cycles elapsed since the
  // accepting edge, the byte being sent and the byte that will be received.
  logic       m_active [2];
  int         m_k      [2];
  logic [7:0] m_tx     [2];
  logic [7:0] m_rx     [2];
  logic [7:0] m_dout   [2];
  logic       m_nd     [2];

  // Advance the frame model; a frame occupies exactly 18 half-periods.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_active[i] <= 1'b0;
        m_k[i]      <= 0;
        m_dout[i]   <= 8'h00;
        m_nd[i]     <= 1'b0;
      end else if (m_active[i]) begin
        if (m_k[i] == 18 * div_of(i) - 1) begin
          m_active[i] <= 1'b0;
          m_nd[i]     <= 1'b1;
          m_dout[i]   <= m_rx[i];
        end else begin
          m_k[i]  <= m_k[i] + 1;
          m_nd[i] <= 1'b0;
        end
      end else begin
        m_nd[i] <= 1'b0;
        if (start_v[i]) begin
          m_active[i] <= 1'b1;
          m_k[i]      <= 0;
          m_tx[i]     <= data_v[i];
          m_rx[i]     <= loop_v[i] ? data_v[i] : {8{tie_v[i]}};
        end
      end
    end
  end

  // Pin values from the half-period index h = k / CLK_DIV: h=0 setup,
  // odd h in 1..15 sck high, bit (7 - h/2) on mosi, h=16 tail, h=17 hold.
  task automatic expectPins(input int d, input logic act, input int k, input logic [7:0] tx,
                            output logic e_busy, output logic e_ss,
                            output logic e_sck, output logic e_mosi);
    int h;
    int idx;
    if (!act) begin
      e_busy = 1'b0; e_ss = 1'b1; e_sck = 1'b0; e_mosi = 1'b0;
    end else begin
      h      = k / d;
      idx    = (h / 2 > 7) ? 7 : h / 2;
      e_busy = 1'b1;
      e_ss   = 1'b0;
      e_sck  = (h >= 1) && (h <= 15) && (h % 2 == 1);
      e_mosi = tx[7 - idx];
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every pin of both instances against the model each cycle.
  initial begin
    logic e_busy, e_ss, e_sck, e_mosi;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          expectPins(div_of(i), m_active[i], m_k[i], m_tx[i], e_busy, e_ss, e_sck, e_mosi);
          checkOutput($sformatf("dut%0d busy", i), {31'd0, busy_w[i]}, {31'd0, e_busy});
          checkOutput($sformatf("dut%0d ss", i), {31'd0, ss_w[i]}, {31'd0, e_ss});
          checkOutput($sformatf("dut%0d sck", i), {31'd0, sck_w[i]}, {31'd0, e_sck});
          checkOutput($sformatf("dut%0d mosi", i), {31'd0, mosi_w[i]}, {31'd0, e_mosi});
          checkOutput($sformatf("dut%0d new_data", i), {31'd0, nd_w[i]}, {31'd0, m_nd[i]});
          checkOutput($sformatf("dut%0d data_out", i), {24'd0, dout_w[i]}, {24'd0, m_dout[i]});
        end
      end
    end
  end

  // Pin statistics used by the directed checks.
  int         rise_cnt      [2] = '{0, 0};
  int         nd_cnt        [2] = '{0, 0};
  int         mosi_hi       [2] = '{0, 0};
  int         busy_run      [2] = '{0, 0};
  int         last_busy_run [2] = '{0, 0};
  int         ss_run        [2] = '{0, 0};
  int         last_ss_run   [2] = '{0, 0};
  logic       prev_sck      [2] = '{1'b0, 1'b0};
  logic [7:0] mosi_byte     [2] = '{8'h00, 8'h00};

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (sck_w[i] && !prev_sck[i]) begin
          rise_cnt[i]++;
          mosi_byte[i] = {mosi_byte[i][6:0], mosi_w[i]};
        end
        prev_sck[i] = sck_w[i];
        if (nd_w[i]) nd_cnt[i]++;
        if (mosi_w[i]) mosi_hi[i]++;
        if (busy_w[i]) busy_run[i]++;
        else begin
          if (busy_run[i] > 0) last_busy_run[i] = busy_run[i];
          busy_run[i] = 0;
        end
        if (ss_w[i]) ss_run[i]++;
        else begin
          if (ss_run[i] > 0) last_ss_run[i] = ss_run[i];
          ss_run[i] = 0;
        end
      end
    end
  end

  task automatic applyStimulus(input int i, input logic [7:0] d);
    @(negedge clk);
    data_v[i]  = d;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    int r0;
    int n0;
    int mh0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; data_v[i] = 8'h00; loop_v[i] = 1'b0; tie_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset data_out", {24'd0, dout_w[0]}, 32'h00);
    checkOutput("reset busy", {31'd0, busy_w[0]}, 32'd0);
    checkOutput("reset new_data", {31'd0, nd_w[0]}, 32'd0);
    checkOutput("reset mosi", {31'd0, mosi_w[0]}, 32'd0);
    checkOutput("reset sck", {31'd0, sck_w[0]}, 32'd0);
    checkOutput("reset ss", {31'd0, ss_w[0]}, 32'd1);
    rst = 1'b0;

    // Loopback A5.
    loop_v[0] = 1'b1;
    r0 = rise_cnt[0]; n0 = nd_cnt[0];
    applyStimulus(0, 8'hA5);
    repeat (80) @(negedge clk);
    checkOutput("loop sck pulses", rise_cnt[0] - r0, 32'd8);
    checkOutput("loop mosi bits", {24'd0, mosi_byte[0]}, 32'hA5);
    checkOutput("loop busy length", last_busy_run[0], 32'd72);
    checkOutput("loop new_data pulses", nd_cnt[0] - n0, 32'd1);
    checkOutput("loop data_out", {24'd0, dout_w[0]}, 32'hA5);

    // miso tied high, then low, sending zeros.
    loop_v[0] = 1'b0; tie_v[0] = 1'b1;
    mh0 = mosi_hi[0];
    applyStimulus(0, 8'h00);
    repeat (80) @(negedge clk);
    checkOutput("miso1 data_out", {24'd0, dout_w[0]}, 32'hFF);
    tie_v[0] = 1'b0;
    applyStimulus(0, 8'h00);
    repeat (80) @(negedge clk);
    checkOutput("miso0 data_out", {24'd0, dout_w[0]}, 32'h00);
    checkOutput("zero mosi high cycles", mosi_hi[0] - mh0, 32'd0);

    // Reset in the middle of XFER.
    tie_v[0] = 1'b1;
    n0 = nd_cnt[0];
    applyStimulus(0, 8'h5A);
    repeat (30) @(negedge clk);
    checkOutput("pre-abort busy", {31'd0, busy_w[0]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort ss", {31'd0, ss_w[0]}, 32'd1);
    checkOutput("abort sck", {31'd0, sck_w[0]}, 32'd0);
    checkOutput("abort busy", {31'd0, busy_w[0]}, 32'd0);
    checkOutput("abort new_data", {31'd0, nd_w[0]}, 32'd0);
    checkOutput("abort data_out", {24'd0, dout_w[0]}, 32'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    checkOutput("abort no completion", nd_cnt[0] - n0, 32'd0);

    // Start and data_in disturbed mid-transfer.
    loop_v[0] = 1'b1;
    r0 = rise_cnt[0]; n0 = nd_cnt[0];
    applyStimulus(0, 8'hA5);
    repeat (9) @(negedge clk);
    applyStimulus(0, 8'h3C);
    repeat (75) @(negedge clk);
    checkOutput("ignored start sck pulses", rise_cnt[0] - r0, 32'd8);
    checkOutput("ignored start mosi bits", {24'd0, mosi_byte[0]}, 32'hA5);
    checkOutput("ignored start data_out", {24'd0, dout_w[0]}, 32'hA5);
    checkOutput("ignored start new_data", nd_cnt[0] - n0, 32'd1);

    // Start held high at CLK_DIV=1: three back-to-back frames.
    loop_v[1] = 1'b1;
    n0 = nd_cnt[1];
    @(negedge clk);
    data_v[1]  = 8'h81;
    start_v[1] = 1'b1;
    repeat (57) @(negedge clk);
    start_v[1] = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("b2b new_data pulses", nd_cnt[1] - n0, 32'd3);
    checkOutput("b2b data_out", {24'd0, dout_w[1]}, 32'h81);
    checkOutput("b2b busy length", last_busy_run[1], 32'd18);
    checkOutput("b2b ss gap", last_ss_run[1], 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
